// File: rtl/uart_boot_loader.sv
// Power-up loader: drives the UART register port to receive a framed image, writes it into
// memory, acknowledges the host, then hands the UART port and the Z80 back to the system.
module uart_boot_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 25175000,
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ucs,
  output logic        urw_n,
  output logic [3:0]  uaddr,
  output logic [7:0]  udata_o,
  input  logic [7:0]  udata_i,
  output logic        bus_own,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_reset_o,
  output logic        done,
  output logic        error,
  output logic [5:0]  dbg_state
);

  // UART port handshake: a register access happens on every clock edge where ucs=1; a read
  // returns udata_i combinationally for the presented uaddr, a write (urw_n=0) takes udata_o.
  // RX avail (addr 3) and TX ready (addr 1) bit 0 act as "valid"/"ready"; reading addr 2 pops.
  typedef enum logic [2:0] {S_POLL, S_READ, S_PROC, S_TXPOLL, S_TXWR, S_DONE} state_t;
  typedef enum logic [2:0] {P_SYNC, P_ADDR_L, P_ADDR_H, P_LEN_L, P_LEN_H, P_DATA, P_CSUM} phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [7:0]  byte_q, byte_n;
  logic [15:0] ptr, ptr_n, remain, remain_n;
  logic [7:0]  sum, sum_n;
  logic        ack, ack_n;
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        ucs_n, urw_n_n, bus_own_n, we_n, cpu_reset_n, done_n, err_n;
  logic [3:0]  uaddr_n;
  logic [7:0]  udata_o_n, mwdata_n;
  logic [15:0] maddr_n;

  assign dbg_state = {phase, state};
  assign tmo_hit   = (state == S_POLL) && (phase != P_SYNC) && (tmo_cnt >= TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    byte_n   = byte_q;
    ptr_n    = ptr;
    remain_n = remain;
    sum_n    = sum;
    ack_n    = ack;
    err_n    = 1'b0;
    we_n     = 1'b0;
    maddr_n  = mem_addr;
    mwdata_n = mem_wdata;
    case (state)
      S_POLL: begin
        // Bus outputs are registered, so only trust udata_i once the avail register is selected.
        if (tmo_hit) begin
          err_n   = 1'b1;
          phase_n = P_SYNC;
        end else if (ucs && urw_n && uaddr == 4'd3 && udata_i[0]) begin
          state_n = S_READ;
        end
      end
      S_READ: begin
        byte_n  = udata_i;
        state_n = S_PROC;
        if (phase == P_DATA) begin
          we_n     = 1'b1;
          maddr_n  = ptr;
          mwdata_n = udata_i;
        end
      end
      S_PROC: begin
        state_n = S_POLL;
        case (phase)
          P_SYNC: begin
            if (byte_q == SYNC_BYTE) begin
              phase_n = P_ADDR_L;
              sum_n   = 8'd0;
            end
          end
          P_ADDR_L: begin ptr_n[7:0]  = byte_q; phase_n = P_ADDR_H; end
          P_ADDR_H: begin ptr_n[15:8] = byte_q; phase_n = P_LEN_L; end
          P_LEN_L:  begin remain_n[7:0] = byte_q; phase_n = P_LEN_H; end
          P_LEN_H: begin
            remain_n = {byte_q, remain[7:0]};
            phase_n  = ({byte_q, remain[7:0]} == 16'd0) ? P_CSUM : P_DATA;
          end
          P_DATA: begin
            sum_n    = sum + byte_q;
            ptr_n    = ptr + 16'd1;
            remain_n = remain - 16'd1;
            if (remain == 16'd1) phase_n = P_CSUM;
          end
          P_CSUM: begin
            ack_n   = (byte_q == sum);
            err_n   = (byte_q != sum);
            state_n = S_TXPOLL;
          end
          default: phase_n = P_SYNC;
        endcase
      end
      S_TXPOLL: if (ucs && uaddr == 4'd1 && udata_i[0]) state_n = S_TXWR;
      S_TXWR: begin
        phase_n = P_SYNC;
        state_n = ack ? S_DONE : S_POLL;
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_POLL;
    endcase

    // Bus and status outputs are registered from the state being entered.
    ucs_n       = 1'b0;
    urw_n_n     = 1'b1;
    uaddr_n     = 4'd0;
    udata_o_n   = 8'd0;
    bus_own_n   = 1'b1;
    cpu_reset_n = 1'b1;
    done_n      = 1'b0;
    case (state_n)
      S_POLL:   begin ucs_n = 1'b1; uaddr_n = 4'd3; end
      S_READ:   begin ucs_n = 1'b1; uaddr_n = 4'd2; end
      S_TXPOLL: begin ucs_n = 1'b1; uaddr_n = 4'd1; end
      S_TXWR: begin
        ucs_n     = 1'b1;
        urw_n_n   = 1'b0;
        udata_o_n = ack_n ? ACK_BYTE : NAK_BYTE;
      end
      S_DONE: begin
        bus_own_n   = 1'b0;
        cpu_reset_n = 1'b0;
        done_n      = 1'b1;
      end
      default: ucs_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_POLL;
      phase       <= P_SYNC;
      byte_q      <= 8'd0;
      ptr         <= 16'd0;
      remain      <= 16'd0;
      sum         <= 8'd0;
      ack         <= 1'b0;
      tmo_cnt     <= 32'd0;
      ucs         <= 1'b0;
      urw_n       <= 1'b1;
      uaddr       <= 4'd0;
      udata_o     <= 8'd0;
      bus_own     <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 8'd0;
      cpu_reset_o <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      byte_q      <= byte_n;
      ptr         <= ptr_n;
      remain      <= remain_n;
      sum         <= sum_n;
      ack         <= ack_n;
      tmo_cnt     <= (state == S_READ || phase == P_SYNC) ? 32'd0 : tmo_cnt + 32'd1;
      ucs         <= ucs_n;
      urw_n       <= urw_n_n;
      uaddr       <= uaddr_n;
      udata_o     <= udata_o_n;
      bus_own     <= bus_own_n;
      mem_we      <= we_n;
      mem_addr    <= maddr_n;
      mem_wdata   <= mwdata_n;
      cpu_reset_o <= cpu_reset_n;
      done        <= done_n;
      error       <= err_n;
    end
  end

endmodule
